// File: rtl/dmem_bank.sv
// dmem_bank: single-port byte-addressable data memory bank.
// Accepts at most one load or store per cycle and returns a one-cycle response
// pulse on the following cycle.
//
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready
// are both high; req_* are don't-care otherwise and are never buffered. rsp_valid
// pulses high for exactly the cycle after the transfer edge; rsp_rdata/rsp_err
// hold their last values while rsp_valid is low.
//
// Optional build macro DMEM_ZERO_INIT_EN: when defined, every release of reset runs
// an INIT sweep that writes zero to each word (one per cycle) before the bank
// accepts requests. When undefined, the bank is ready one cycle after reset
// release and its contents are undefined until written.
module dmem_bank #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [0:0]        dbg_state
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [31:0]      mem [DEPTH];
    logic [0:0]       state;
    logic             rsp_valid_q;
    logic             accept;
    logic             in_range;
    logic             req_err;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_data;
    logic [3:0]       wr_mask;
    logic [31:0]      wr_lanes;

`ifdef DMEM_ZERO_INIT_EN
    logic [IDX_W-1:0] sweep_idx;
    assign req_ready = (state == ST_IDLE);
`else
    // Set on the first edge after reset is released; holds the bank not-ready
    // for that one cycle so nothing is accepted while reset is asserted.
    logic live;
    assign req_ready = (state == ST_IDLE) && live;
`endif

    assign dbg_state = state;
    // A pending response is dropped as soon as reset is asserted.
    assign rsp_valid = rsp_valid_q && rst;
    assign accept    = req_valid && req_ready && rst;
    assign in_range  = ((req_addr >> (IDX_W + 2)) == '0);
    assign word_idx  = req_addr[IDX_W+1:2];
    assign lane      = req_addr[1:0];
    assign rd_word   = mem[word_idx];
    assign rd_half   = lane[1] ? rd_word[31:16] : rd_word[15:0];

    // Decode faults, extract/extend load data and build the store lane mask.
    always_comb begin
        req_err   = !in_range;
        rd_byte   = rd_word[7:0];
        load_data = rd_word;
        wr_mask   = 4'b0000;
        wr_lanes  = req_wdata;
        case (lane)
            2'd0: rd_byte = rd_word[7:0];
            2'd1: rd_byte = rd_word[15:8];
            2'd2: rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        case (req_size)
            SZ_BYTE: begin
                load_data = {{24{!req_unsigned && rd_byte[7]}}, rd_byte};
                wr_mask   = 4'b0001 << lane;
                wr_lanes  = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                req_err   = req_err || lane[0];
                load_data = {{16{!req_unsigned && rd_half[15]}}, rd_half};
                wr_mask   = lane[1] ? 4'b1100 : 4'b0011;
                wr_lanes  = {2{req_wdata[15:0]}};
            end
            SZ_WORD: begin
                req_err   = req_err || (lane != 2'b00);
                load_data = rd_word;
                wr_mask   = 4'b1111;
                wr_lanes  = req_wdata;
            end
            default: begin
                req_err = 1'b1;
            end
        endcase
    end

    // Memory array: zero sweep during INIT, lane-masked writes for good stores; never reset.
    always_ff @(posedge clk) begin
`ifdef DMEM_ZERO_INIT_EN
        if (rst && state == ST_INIT) begin
            mem[sweep_idx] <= 32'h0;
        end else
`endif
        if (accept && req_we && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

    // Control state and registered response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata   <= 32'h0;
            rsp_err     <= 1'b0;
`ifdef DMEM_ZERO_INIT_EN
            state       <= ST_INIT;
            sweep_idx   <= '0;
`else
            state       <= ST_IDLE;
            live        <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_err   <= req_err;
                rsp_rdata <= (req_we || req_err) ? 32'h0 : load_data;
            end
`ifdef DMEM_ZERO_INIT_EN
            if (state == ST_INIT) begin
                sweep_idx <= sweep_idx + 1'b1;
                if (sweep_idx == IDX_W'(DEPTH - 1)) begin
                    state <= ST_IDLE;
                end
            end
`else
            live <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_bank.sv
// tb_dmem_bank: self-checking bench for dmem_bank, built with or without
// DMEM_ZERO_INIT_EN. The reference model is a flat byte array with per-byte
// "known" flags.
module tb_dmem_bank;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 32;
    localparam int NBYTES = 4 * DEPTH;
`ifdef DMEM_ZERO_INIT_EN
    localparam int EXP_LAT = DEPTH;
`else
    localparam int EXP_LAT = 1;
`endif

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [0:0]        dbg_state;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem   [NBYTES];
    bit         ref_known [NBYTES];

    dmem_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .dbg_state    (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: byte-addressed little-endian memory.
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] er, output logic ee, output bit known);
        int nb;
        bit bad;
        logic [31:0] val;
        nb    = 1 << size;
        bad   = (size == 2'd3) || (addr >= NBYTES) ||
                (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
        er    = 32'h0;
        ee    = bad;
        known = 1'b1;
        if (!bad && we) begin
            for (int i = 0; i < nb; i++) begin
                ref_mem[addr + i]   = wdata[8*i +: 8];
                ref_known[addr + i] = 1'b1;
            end
        end else if (!bad) begin
            val = 32'h0;
            for (int i = 0; i < nb; i++) begin
                val[8*i +: 8] = ref_mem[addr + i];
                if (!ref_known[addr + i]) known = 1'b0;
            end
            if (!uns && nb < 4 && val[8*nb-1] === 1'b1) begin
                for (int i = 8 * nb; i < 32; i++) val[i] = 1'b1;
            end
            er = val;
        end
    endtask

    // Driver: present one request at a negedge, check the response one cycle later.
    // Leaves req_valid high so consecutive calls are back-to-back.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input string name);
        logic [31:0] er;
        logic ee;
        bit known;
        model(we, size, uns, addr, wdata, er, ee, known);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: got %b expected 1", name, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: got %b expected 1", name, rsp_valid);
        end
        checks++;
        if (rsp_err !== ee) begin
            errors++;
            $display("FAIL %s_err: got %b expected %b", name, rsp_err, ee);
        end
        if (known) begin
            checks++;
            if (rsp_rdata !== er) begin
                errors++;
                $display("FAIL %s_rdata: got %h expected %h", name, rsp_rdata, er);
            end
        end
    endtask

    // Driver: one cycle with no request (random junk on the other inputs).
    task automatic idle(input string name);
        req_valid    = 1'b0;
        req_we       = 1'($urandom_range(0, 1));
        req_size     = 2'($urandom_range(0, 3));
        req_addr     = $urandom;
        req_wdata    = $urandom;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_valid: got %b expected 0", name, rsp_valid);
        end
    endtask

    // Hold reset for some edges with a junk store pending, then measure ready latency.
    task automatic do_reset(input int edges, input string name);
        int  n;
        bit  early_rsp;
        @(negedge clk);
        rst          = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = 32'h10;
        req_wdata    = 32'hDEADBEEF;
        repeat (edges) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_in_reset: got valid=%b err=%b rdata=%h ready=%b expected 0 0 00000000 0",
                     name, rsp_valid, rsp_err, rsp_rdata, req_ready);
        end
        rst = 1'b1;
`ifdef DMEM_ZERO_INIT_EN
        for (int i = 0; i < NBYTES; i++) begin
            ref_mem[i]   = 8'h00;
            ref_known[i] = 1'b1;
        end
`endif
        n = 0;
        early_rsp = 1'b0;
        while (n < EXP_LAT + 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (rsp_valid !== 1'b0) early_rsp = 1'b1;
            if (req_ready === 1'b1) break;
        end
        req_valid = 1'b0;
        checks++;
        if (n != EXP_LAT || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_latency: got %0d cycles (ready=%b) expected %0d", name, n, req_ready, EXP_LAT);
        end
        checks++;
        if (early_rsp) begin
            errors++;
            $display("FAIL %s_no_rsp_while_not_ready: got rsp_valid=1 expected 0", name);
        end
    endtask

    task automatic test_reset();
        do_reset(3, "reset");
    endtask

    task automatic test_top_word();
`ifndef DMEM_ZERO_INIT_EN
        issue(1'b1, 2'd2, 1'b0, 32'h3FC, 32'h12345678, "top_store");
`endif
        issue(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, "top_load");
        idle("top");
    endtask

    task automatic test_lanes();
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h8899AABB, "lanes_sw");
        issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h00000055, "lanes_sb");
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lanes_lw");
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, "lanes_lb");
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, "lanes_lbu");
        issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, "lanes_lhu");
        idle("lanes");
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234F00D, "b2b_sh");
        issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, "b2b_lh");
        issue(1'b1, 2'd0, 1'b0, 32'h20, 32'h000000A5, "b2b_sb");
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "b2b_lw");
        idle("b2b");
    endtask

    task automatic test_errors();
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, "err_setup");
        issue(1'b1, 2'd2, 1'b0, 32'h21, 32'hCAFEBABE, "err_sw_mis");
        issue(1'b0, 2'd1, 1'b0, 32'h23, 32'h0, "err_lh_mis");
        issue(1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFFFFFF, "err_size11");
        issue(1'b0, 2'd0, 1'b0, 32'h400, 32'h0, "err_oob");
        issue(1'b1, 2'd0, 1'b0, 32'hFFFFFF00, 32'h77, "err_oob_hi");
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "err_unchanged");
        idle("err");
    endtask

    task automatic test_random();
        logic [1:0]  size;
        logic [31:0] addr;
        for (int w = 0; w < 16; w++) begin
            issue(1'b1, 2'd2, 1'b0, 32'h100 + 32'(4 * w), $urandom, "rnd_init");
        end
        for (int n = 0; n < 300; n++) begin
            size = 2'($urandom_range(0, 3));
            addr = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'd1) addr[0] = 1'b0;
                if (size == 2'd2) addr[1:0] = 2'b00;
            end
            if ($urandom_range(0, 7) == 0) addr = 32'h400 + 32'($urandom_range(0, 4095));
            issue(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom, "rnd");
            if ($urandom_range(0, 4) == 0) idle("rnd");
        end
        idle("rnd_end");
    endtask

    task automatic test_reset_pending();
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = 32'h10;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstpend_valid: got %b expected 0", rsp_valid);
        end
        do_reset(2, "rstpend");
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "rstpend_lw");
        idle("rstpend");
    endtask

    initial begin
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        for (int i = 0; i < NBYTES; i++) ref_known[i] = 1'b0;
        test_reset();
        test_top_word();
        test_lanes();
        test_back_to_back();
        test_errors();
        test_random();
        test_reset_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_bank.md
DMEM_BANK -- requirements
Module: dmem_bank

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words (power of two, >= 4).
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port req_unsigned  input  1  loads: 1 zero-extend, 0 sign-extend.
REQ-010 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-011 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  request faulted, valid with rsp_valid.

Function
REQ-015 SHALL implement states INIT and IDLE; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a clk edge where req_valid && req_ready; one request per cycle maximum.
REQ-017 SHALL assert rsp_valid exactly one cycle after acceptance, for one cycle, with rsp_rdata/rsp_err; otherwise rsp_valid = 0 and rsp_rdata/rsp_err hold previous values.
REQ-018 SHALL flag error when req_size = 11, when half with addr[0] = 1, when word with addr[1:0] != 00, or when req_addr >= 4*DEPTH.
REQ-019 SHALL NOT modify memory on an errored store; errored loads return rsp_rdata = 0.
REQ-020 SHALL on a valid store write only the addressed lanes: byte to lane addr[1:0], half to lanes addr[1]*2..+1, word to all four; other lanes unchanged.
REQ-021 SHALL on a valid load extract the addressed byte/half/word (little-endian) and extend per req_unsigned to 32 bits.
REQ-022 SHALL return the newly written value for a load to the same word accepted the cycle after a store (no stale read).
REQ-023 SHALL ignore req_* inputs while req_ready = 0 (no buffering, no response).

Reset
REQ-024 SHALL, while rst = 0 at a clk edge, set rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 0, discard any pending response.
REQ-025 SHALL on release of rst enter INIT (macro defined) or IDLE (macro undefined); reset mid-sweep restarts the sweep at index 0.
REQ-026 SHALL NOT clear memory contents on reset itself.

Configuration
REQ-027 SHALL, with DMEM_ZERO_INIT_EN defined, sweep INIT writing 0 to word indices 0..DEPTH-1, one per cycle, then enter IDLE (req_ready first high DEPTH cycles after reset release).
REQ-028 SHALL, without DMEM_ZERO_INIT_EN, omit INIT and sweep counter; req_ready goes high the first cycle after reset release; contents undefined until written.

Verification
REQ-029 SHALL check: DEPTH=256, macro on, reset release -> req_ready low 256 cycles, then high; load word 0x3FC -> rdata 0x00000000, err 0.
REQ-030 SHALL check: store word 0x10 = 0x8899AABB, store byte 0x11 = 0x55 -> load word 0x10 = 0x889955BB; load byte 0x13 signed -> 0xFFFFFF88, unsigned -> 0x00000088.
REQ-031 SHALL check: store half 0x22 = 0xF00D, next-cycle load half 0x22 signed -> 0xFFFFF00D, rsp_valid exactly one cycle after each acceptance.
REQ-032 SHALL check: store word 0x21, load half 0x23, size 11, addr 0x400 -> each rsp_err = 1, rdata 0, word 0x20 unchanged.
REQ-033 SHALL check: rst low on the cycle after a load acceptance -> no rsp_valid; macro on -> INIT restarts, req_ready low 256 cycles; previously written word 0x10 reads 0 after sweep.
